// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bus of the sequential divider
interface seq_divider_if #(parameter int WIDTH = 16);
   logic             start;
   logic [WIDTH-1:0] dividend_hi;
   logic [WIDTH-1:0] dividend_lo;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             of;
   logic             div_by_zero;
   logic             busy;
   logic             done;
   modport master (output start, dividend_hi, dividend_lo, divisor,
                   input quot, rem, of, div_by_zero, busy, done);
   modport slave (input start, dividend_hi, dividend_lo, divisor,
                  output quot, rem, of, div_by_zero, busy, done);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, {dividend_hi,dividend_lo} / divisor -> quot, rem.
// Define SEQ_DIVIDER_RADIX4_EN to retire two quotient bits per cycle.
module seq_divider #(parameter int WIDTH = 16) (
   input logic clk,
   input logic rst,
   seq_divider_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`ifdef SEQ_DIVIDER_RADIX4_EN
   localparam int ITER = WIDTH / 2;
`else
   localparam int ITER = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH);
   state_t state, nxt;
   logic [WIDTH-1:0] r, q, d, r_n, q_n;
   logic [CW-1:0] cnt;
   logic err;
   function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] rq, input logic [WIDTH-1:0] dv);
      logic [WIDTH:0] t, s;
      logic ge;
      t = rq[2*WIDTH-1:WIDTH-1];
      s = t - {1'b0, dv};
      ge = t >= {1'b0, dv};
      step = {ge ? s[WIDTH-1:0] : t[WIDTH-1:0], rq[WIDTH-2:0], ge};
   endfunction
   assign err = bus.divisor == '0 || bus.dividend_hi >= bus.divisor;
   always_comb begin
`ifdef SEQ_DIVIDER_RADIX4_EN
      {r_n, q_n} = step(step({r, q}, d), d);
`else
      {r_n, q_n} = step({r, q}, d);
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = state == IDLE ? (bus.start ? (err ? DONE : CALC) : IDLE) :
            state == CALC ? (cnt == '0 ? DONE : CALC) : IDLE;
   always_comb begin
      bus.busy = state == CALC;
      bus.done = state == DONE;
   end
   // Results only change on DONE entry; accepting a new start leaves them intact.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r               <= '0;
         q               <= '0;
         d               <= '0;
         cnt             <= '0;
         bus.quot        <= '0;
         bus.rem         <= '0;
         bus.of          <= 1'b0;
         bus.div_by_zero <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         r   <= bus.dividend_hi;
         q   <= bus.dividend_lo;
         d   <= bus.divisor;
         cnt <= CW'(ITER - 1);
         if (err) begin
            bus.quot        <= '1;
            bus.rem         <= '0;
            bus.of          <= bus.divisor != '0;
            bus.div_by_zero <= bus.divisor == '0;
         end
      end else if (state == CALC) begin
         r   <= r_n;
         q   <= q_n;
         cnt <= cnt - 1'b1;
         if (cnt == '0) begin
            bus.quot        <= q_n;
            bus.rem         <= r_n;
            bus.of          <= 1'b0;
            bus.div_by_zero <= 1'b0;
         end
      end
endmodule
